// File: rtl/counter_seq_ctrl.sv
// Bounded up/down step counter sequenced by an IDLE/RUN/PAUSE command FSM.
// A prescaler paces steps at one per DIV clocks while running; all outputs are registered.
module counter_seq_ctrl #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       start,
  input  logic       stop,
  input  logic       dir_tgl,
  input  logic       mode,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic [7:0] q,
  output logic       ud,
  output logic       tick,
  output logic       bound,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam logic [24:0] PRESC_MAX = 25'(DIV - 1);

  state_e      state_q, state_d;
  logic [24:0] presc_q, presc_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        ud_q, ud_d;
  logic        tick_q, tick_d;
  logic        bound_q, bound_d;

  logic        step;
  logic        at_lim;
  logic        load;
  logic [7:0]  step_q;
  logic        step_ud;

  always_ff @(posedge clk) begin
    if (rs) begin
      state_q <= IDLE;
      presc_q <= '0;
      q_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ud_q    <= 1'b1;
      tick_q  <= 1'b0;
      bound_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      q_q     <= q_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ud_q    <= ud_d;
      tick_q  <= tick_d;
      bound_q <= bound_d;
    end
  end

  // Stop outranks start in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!stop && start) state_d = RUN;
      RUN:     if (stop) state_d = PAUSE;
      PAUSE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step    = (state_q == RUN) && (presc_q == PRESC_MAX);
    at_lim  = ud_q ? (q_q == hi_q) : (q_q == lo_q);
    load    = (state_q == IDLE) && (state_d == RUN);
    step_q  = q_q;
    step_ud = ud_q;
    // Equal bounds freeze q and ud; only bound fires on each tick.
    if (step && (lo_q != hi_q)) begin
      if (!at_lim) begin
        step_q = ud_q ? q_q + 8'd1 : q_q - 8'd1;
      end else if (!mode) begin
        step_q = ud_q ? lo_q : hi_q;
      end else begin
        step_ud = ~ud_q;
        step_q  = ud_q ? hi_q - 8'd1 : lo_q + 8'd1;
      end
    end

    presc_d = ((state_q == RUN) && (state_d == RUN) && !step) ? presc_q + 25'd1 : '0;

    lo_d = lo_q;
    hi_d = hi_q;
    q_d  = step_q;
    if (load) begin
      lo_d = (lo > hi) ? hi : lo;
      hi_d = (lo > hi) ? lo : hi;
      q_d  = (lo > hi) ? hi : lo;
    end

    ud_d    = step_ud ^ dir_tgl;
    tick_d  = step;
    bound_d = step && at_lim;
  end

  always_comb begin
    q     = q_q;
    ud    = ud_q;
    tick  = tick_q;
    bound = bound_q;
    state = state_q;
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboarded bench for counter_seq_ctrl: directed scenarios then random commands,
// every cycle's outputs predicted by a cycle-level behavioural model.
module tb_counter_seq_ctrl;
  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rs, start, stop, dir_tgl, mode;
  logic [7:0] lo, hi;
  logic [7:0] q;
  logic       ud, tick, bound;
  logic [1:0] state;

  counter_seq_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rs(rs), .start(start), .stop(stop), .dir_tgl(dir_tgl),
    .mode(mode), .lo(lo), .hi(hi), .q(q), .ud(ud), .tick(tick),
    .bound(bound), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] q;
    logic       ud;
    logic       tick;
    logic       bound;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_vec  = 0;
  int   n_fail = 0;

  // Model state: 0 idle, 1 run, 2 pause; m_pc counts cycles spent in the current run stretch.
  int m_st, m_pc, m_lo, m_hi, m_q;
  bit m_ud, m_tick, m_bound;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit p, input bit t,
                            input bit md, input int l, input int h);
    int nq, lim, nst;
    bit nud;
    if (r) begin
      m_st = 0; m_pc = 0; m_lo = 0; m_hi = 0; m_q = 0;
      m_ud = 1; m_tick = 0; m_bound = 0;
      return;
    end
    m_tick  = (m_st == 1) && (m_pc % DIV == DIV - 1);
    m_bound = 0;
    nq  = m_q;
    nud = m_ud;
    if (m_tick) begin
      lim     = m_ud ? m_hi : m_lo;
      m_bound = (m_q == lim);
      if (m_lo != m_hi) begin
        if (!m_bound)  nq = m_ud ? m_q + 1 : m_q - 1;
        else if (!md)  nq = m_ud ? m_lo : m_hi;
        else begin
          nud = !m_ud;
          nq  = m_ud ? m_hi - 1 : m_lo + 1;
        end
      end
    end
    nst = m_st;
    if (p) begin
      if (m_st == 1) nst = 2;
      else if (m_st == 2) nst = 0;
    end else if (s) begin
      if (m_st == 0) begin
        m_lo = (l < h) ? l : h;
        m_hi = (l < h) ? h : l;
        nq   = m_lo;
        nst  = 1;
      end else if (m_st == 2) nst = 1;
    end
    m_pc = (nst == 1 && m_st == 1) ? m_pc + 1 : 0;
    m_st = nst;
    m_q  = nq;
    m_ud = nud ^ t;
  endtask

  task automatic cycle(input bit r, input bit s, input bit p, input bit t);
    exp_t e;
    @(negedge clk);
    rs = r; start = s; stop = p; dir_tgl = t;
    @(posedge clk);
    model_step(r, s, p, t, mode, int'(lo), int'(hi));
    e.st = 2'(m_st); e.q = 8'(m_q); e.ud = m_ud; e.tick = m_tick; e.bound = m_bound;
    sb.push_back(e);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(0, 0, 0, 0);
      if (tick === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk("outputs{st,q,ud,tick,bound}", {19'd0, state, q, ud, tick, bound}, {19'd0, e_mon});
    end
  end

  initial begin
    int n, ticks;
    int e035[4]  = '{4, 5, 3, 4};
    int b035[4]  = '{0, 0, 1, 0};
    int e036[5]  = '{4, 5, 4, 3, 4};
    int u036[5]  = '{1, 1, 0, 0, 1};
    int b036[5]  = '{0, 0, 1, 0, 1};
    bit s, p;
    int r;

    rs = 1'b0; start = 1'b0; stop = 1'b0; dir_tgl = 1'b0;
    mode = 1'b0; lo = 8'd3; hi = 8'd5;

    // Reset then wrap mode
    cycle(1, 0, 0, 0);
    chk("rst_q", q, 0); chk("rst_ud", ud, 1); chk("rst_state", state, 0);
    chk("rst_tick", tick, 0); chk("rst_bound", bound, 0);
    cycle(0, 1, 0, 0);
    chk("wrap_load_q", q, 3); chk("wrap_state", state, 1);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      chk("wrap_tick_gap", n, 4); chk("wrap_q", q, e035[i]); chk("wrap_bound", bound, b035[i]);
    end

    // Bounce mode
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    mode = 1'b1;
    cycle(0, 1, 0, 0);
    chk("bnc_load_q", q, 3);
    for (int i = 0; i < 5; i++) begin
      wait_tick(n);
      chk("bnc_q", q, e036[i]); chk("bnc_ud", ud, u036[i]); chk("bnc_bound", bound, b036[i]);
    end

    // Swapped bounds, later lo/hi changes ignored
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    lo = 8'd9; hi = 8'd2;
    cycle(0, 1, 0, 0);
    chk("swap_load_q", q, 2);
    lo = 8'd0; hi = 8'd255;
    for (int v = 3; v <= 9; v++) begin
      wait_tick(n);
      chk("swap_q", q, v);
    end
    wait_tick(n);
    chk("swap_hi_bounce_q", q, 8); chk("swap_hi_bounce_ud", ud, 0);
    cycle(0, 0, 0, 1);
    chk("tgl_idle_step_ud", ud, 1);

    // Pause / resume
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    chk("to_idle_state", state, 0);
    mode = 1'b0; lo = 8'd3; hi = 8'd5;
    cycle(0, 1, 0, 0);
    wait_tick(n);
    chk("pr_q4", q, 4);
    cycle(0, 0, 1, 0);
    chk("pause_state", state, 2);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0);
      if (tick === 1'b1) ticks++;
    end
    chk("pause_no_tick", ticks, 0); chk("pause_q_hold", q, 4);
    cycle(0, 1, 0, 0);
    chk("resume_state", state, 1);
    wait_tick(n);
    chk("resume_gap", n, 4); chk("resume_q", q, 5);
    wait_tick(n); chk("resume_wrap_q", q, 3);
    wait_tick(n); chk("resume_q4", q, 4);
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);
    chk("stop2_state", state, 0); chk("stop2_q_kept", q, 4);

    // Simultaneous events
    cycle(0, 1, 0, 0); cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    chk("both_in_pause_state", state, 0);
    cycle(0, 1, 0, 0);
    wait_tick(n);
    chk("pre_tgl_q", q, 4); chk("pre_tgl_ud", ud, 1);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("tgl_tick", tick, 1); chk("tgl_q", q, 5); chk("tgl_ud", ud, 0);

    // Reset on a tick edge
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_run_q", q, 0); chk("rst_run_ud", ud, 1); chk("rst_run_state", state, 0);
    chk("rst_run_tick", tick, 0); chk("rst_run_bound", bound, 0);

    // Random commands
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        lo = 8'($urandom);
        r  = $urandom_range(0, 3);
        if (r == 0)      hi = lo;
        else if (r == 3) hi = 8'($urandom);
        else             hi = 8'(int'(lo) + $urandom_range(0, 6));
      end
      s = ($urandom_range(0, 11) == 0);
      p = ($urandom_range(0, 19) == 0);
      if (s && p) s = 1'b0;
      cycle(($urandom_range(0, 399) == 0), s, p, ($urandom_range(0, 29) == 0));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
